// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, hazard FSM state type and
// register-specifier width default.
package core_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [5:0] OP_HALT = 6'b010001;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_BZ   = 6'b001110;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: flags an ID instruction reading a register
// that the load currently in EX has not yet produced.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_is_load,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rd == id_rs);
    assign rt_hit = id_uses_rt && (ex_rd == id_rt);

    // Register 0 is hard-wired, so a load targeting it can never create a hazard.
    assign load_use = id_valid && ex_is_load && ex_regwrite && (ex_rd != '0)
                      && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC hold, next-PC select, IF/ID flush and
// ID/EX bubble for load-use, taken branch and HALT. Optional HAZARD_PERF_EN
// adds saturating stall/flush event counters.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_AW         = REG_AW_DEF,
    parameter int BRANCH_PENALTY = 1,
    parameter int OPC_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_is_load,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    output logic              hazard,
    output logic              pc_sel,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              halted,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic [1:0]        state
);

    hz_state_t state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       load_use;
    logic       halt_op;
    logic       stall_evt;
    logic       flush_evt;

    load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_is_load  (ex_is_load),
        .ex_regwrite (ex_regwrite),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign halt_op = id_valid && (id_opcode == OPC_W'(OP_HALT));

    always_ff @(posedge clk) begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
    end

    always_comb begin
        hazard       = 1'b0;
        pc_sel       = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            RUN: begin
                // A taken branch squashes whatever sits in ID, so it outranks stalls.
                if (ex_branch_taken) begin
                    pc_sel       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush_evt    = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_next = FLUSH;
                        cnt_next   = 2'(BRANCH_PENALTY - 1);
                    end
                end else if (load_use) begin
                    hazard       = 1'b1;
                    id_ex_bubble = 1'b1;
                    stall_evt    = 1'b1;
                end else if (halt_op) begin
                    hazard       = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_next   = HALT;
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                cnt_next    = cnt_reg - 2'd1;
                if (cnt_reg <= 2'd1) begin
                    state_next = RUN;
                    cnt_next   = 2'd0;
                end
            end
            HALT: begin
                hazard       = 1'b1;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                state_next = RUN;
                cnt_next   = 2'd0;
            end
        endcase
        if (rst) begin
            hazard       = 1'b0;
            pc_sel       = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            halted       = 1'b0;
            stall_evt    = 1'b0;
            flush_evt    = 1'b0;
            state_next   = RUN;
            cnt_next     = 2'd0;
        end
    end

    assign state = rst ? RUN : state_reg;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (stall_evt && (perf_stall_reg != '1))
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if (flush_evt && (perf_flush_reg != '1))
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_reg;
    assign perf_flush_cnt = perf_flush_reg;
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: two instances (penalty 1 and 3) driven in
// lockstep, compared every cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    import core_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic       ex_is_load, ex_regwrite;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;

    logic       hz_a, pc_a, fl_a, bb_a, ht_a;
    logic [1:0] st_a;
    logic       hz_b, pc_b, fl_b, bb_b, ht_b;
    logic [1:0] st_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] ps_a, pf_a, ps_b, pf_b;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state per instance
    int pen[2] = '{1, 3};
    int flush_left[2];
    bit halt_m[2];
    int stall_m[2];
    int flushc_m[2];
    int nxt_flush[2];
    bit nxt_halt[2];
    int nxt_stall[2];
    int nxt_flushc[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .BRANCH_PENALTY(1), .OPC_W(6)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .hazard(hz_a), .pc_sel(pc_a), .if_id_flush(fl_a), .id_ex_bubble(bb_a),
        .halted(ht_a),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(ps_a), .perf_flush_cnt(pf_a),
`endif
        .state(st_a)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .BRANCH_PENALTY(3), .OPC_W(6)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .hazard(hz_b), .pc_sel(pc_b), .if_id_flush(fl_b), .id_ex_bubble(bb_b),
        .halted(ht_b),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(ps_b), .perf_flush_cnt(pf_b),
`endif
        .state(st_b)
    );

    // One cycle: drive inputs, check both instances against the model, advance.
    task automatic step(input bit r, input bit v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                        input bit ld, input bit rw, input logic [4:0] rd,
                        input bit br, input string tag);
        logic [6:0] exp_v, obs_v;
        bit lu, hop;
        bit e_hz, e_pc, e_fl, e_bb, e_ht;
        int e_st;
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt;
        id_uses_rt = urt; ex_is_load = ld; ex_regwrite = rw; ex_rd = rd;
        ex_branch_taken = br;
        #1;
        lu  = v && ld && rw && (rd != 0) && ((rd == rs) || (urt && rd == rt));
        hop = v && (op == 6'b010001);
        for (int k = 0; k < 2; k++) begin
            {e_hz, e_pc, e_fl, e_bb, e_ht} = '0;
            e_st = 0;
            nxt_flush[k] = flush_left[k];
            nxt_halt[k]  = halt_m[k];
            nxt_stall[k] = stall_m[k];
            nxt_flushc[k] = flushc_m[k];
            if (r) begin
                nxt_flush[k] = 0; nxt_halt[k] = 0;
                nxt_stall[k] = 0; nxt_flushc[k] = 0;
            end else if (halt_m[k]) begin
                e_hz = 1; e_bb = 1; e_ht = 1; e_st = 2;
            end else if (flush_left[k] > 0) begin
                e_fl = 1; e_st = 1;
                nxt_flush[k] = flush_left[k] - 1;
            end else if (br) begin
                e_pc = 1; e_fl = 1; e_bb = 1;
                nxt_flush[k] = pen[k] - 1;
                nxt_flushc[k] = flushc_m[k] + 1;
            end else if (lu) begin
                e_hz = 1; e_bb = 1;
                nxt_stall[k] = stall_m[k] + 1;
            end else if (hop) begin
                e_hz = 1; e_bb = 1;
                nxt_halt[k] = 1;
            end
            exp_v = {e_hz, e_pc, e_fl, e_bb, e_ht, 2'(e_st)};
            obs_v = (k == 0) ? {hz_a, pc_a, fl_a, bb_a, ht_a, st_a}
                             : {hz_b, pc_b, fl_b, bb_b, ht_b, st_b};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s pen=%0d {hazard,pc_sel,flush,bubble,halted,state} got %b expected %b",
                       tag, pen[k], obs_v, exp_v);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            assert (((k == 0) ? {ps_a, pf_a} : {ps_b, pf_b}) ===
                    {32'(stall_m[k]), 32'(flushc_m[k])}) else begin
                errors++;
                $error("FAIL %s_perf pen=%0d got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                       tag, pen[k], (k == 0) ? ps_a : ps_b, (k == 0) ? pf_a : pf_b,
                       stall_m[k], flushc_m[k]);
            end
`endif
        end
        $display("step %-10s rst=%0b v=%0b op=%b rs=%0d rt=%0d urt=%0b ld=%0b rw=%0b rd=%0d br=%0b | A=%b B=%b",
                 tag, r, v, op, rs, rt, urt, ld, rw, rd, br,
                 {hz_a, pc_a, fl_a, bb_a, ht_a, st_a}, {hz_b, pc_b, fl_b, bb_b, ht_b, st_b});
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            flush_left[k] = nxt_flush[k];
            halt_m[k]     = nxt_halt[k];
            stall_m[k]    = nxt_stall[k];
            flushc_m[k]   = nxt_flushc[k];
        end
    endtask

    task automatic idle(input string tag);
        step(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, tag);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            flush_left[k] = 0; halt_m[k] = 0; stall_m[k] = 0; flushc_m[k] = 0;
        end
        // reset
        step(1, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, "reset");
        step(1, 1, 6'b010001, 5'd5, 5'd5, 1, 1, 1, 5'd5, 1, "reset_busy");
        idle("post_rst");
        // load-use on rs, then bubble in EX
        step(0, 1, 6'd0, 5'd5, 5'd1, 0, 1, 1, 5'd5, 0, "lu_rs");
        step(0, 1, 6'd0, 5'd5, 5'd1, 0, 0, 0, 5'd0, 0, "lu_after");
        // no false stall
        step(0, 1, 6'd0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, "rd_zero");
        step(0, 1, 6'd0, 5'd1, 5'd7, 0, 1, 1, 5'd7, 0, "rt_unused");
        step(0, 1, 6'd0, 5'd1, 5'd7, 1, 1, 1, 5'd7, 0, "lu_rt");
        step(0, 1, 6'd0, 5'd1, 5'd7, 1, 1, 0, 5'd7, 0, "no_regwr");
        step(0, 0, 6'd0, 5'd7, 5'd7, 1, 1, 1, 5'd7, 0, "id_invalid");
        step(0, 1, 6'd0, 5'd23, 5'd2, 0, 1, 1, 5'd7, 0, "bits_diff");
        // branch and flush window, with a branch during FLUSH ignored
        step(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, "branch");
        step(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, "br_in_fl");
        idle("flush2");
        idle("flush_end");
        // branch beats load-use and HALT
        step(0, 1, 6'b010001, 5'd4, 5'd4, 1, 1, 1, 5'd4, 1, "br_prio");
        idle("prio_f1");
        idle("prio_f2");
        idle("prio_run");
        // load-use beats HALT
        step(0, 1, 6'b010001, 5'd9, 5'd0, 0, 1, 1, 5'd9, 0, "lu_vs_halt");
        // HALT held 50 cycles with noisy inputs
        step(0, 1, 6'b010001, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, "halt");
        for (int i = 0; i < 50; i++)
            step(0, 1'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), "halt_hold");
        step(1, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, "halt_rst");
        idle("after_halt");
        // randomized traffic, occasional reset to escape HALT
        for (int i = 0; i < 400; i++) begin
            automatic logic [5:0] op = ($urandom_range(0, 7) == 0) ? 6'b010001 : 6'($urandom);
            step(($urandom_range(0, 24) == 0), 1'($urandom), op,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), "random");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
